core_ex_alu: RTL
================

Name: core_ex_alu

Overview:
- Execute-stage ALU in the RISC-V core pipeline.
- Consumes the 4-bit alu_op produced by the ID-stage ALU decoder, together with the two resolved operands, and computes the result.
- Registers the result into the EX/MEM boundary behind a valid/ready handshake, with flush support.
- Operation encodings are the `ALU_OP_*` macros from core_define.sv.

Parameters:
- XLEN, 32, datapath width; shift amount is op2[$clog2(XLEN)-1:0].

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  pipeline flush from branch/exception logic.
- in_valid  input  1  ID/EX entry valid.
- in_ready  output  1  ALU can accept the entry this cycle.
- in_alu_op  input  4  `ALU_OP_*` code.
- in_op1  input  XLEN  operand 1 (rs1 / pc / csr value).
- in_op2  input  XLEN  operand 2 (rs2 / imm / csr mask).
- in_rd_addr  input  5  destination register index.
- in_rd_wen  input  1  destination write enable.
- out_valid  output  1  result register holds a valid entry.
- out_ready  input  1  MEM stage accepts the entry.
- out_result  output  XLEN  registered ALU result.
- out_rd_addr  output  5  registered rd index.
- out_rd_wen  output  1  registered rd write enable.
- busy  output  1  multi-cycle shift in progress (always 0 without the feature).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_result=0, out_rd_addr=0, out_rd_wen=0, busy=0, FSM=IDLE. Applies immediately, including mid-shift.
- Handshake: in_ready = !flush && !busy && (!out_valid || out_ready). Accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Inputs must be held stable while in_valid=1 and in_ready=0.
- Operations (single-cycle; result registered on the accept edge, so latency 1):
  - ADD: op1+op2, mod 2^XLEN.
  - SUB: op1-op2, mod 2^XLEN.
  - SLL, SRL: logical shifts by shamt.
  - SRA: arithmetic shift right, sign of op1[XLEN-1] filled in.
  - SLT: 1 if op1 < op2 signed, else 0 (zero-extended).
  - SLTU: same comparison, unsigned.
  - XOR, OR, AND: bitwise.
  - NOT_AND: op1 & ~op2.
  - Any undefined code: result 0; entry still passes with its rd fields.
- Output register:
  - Loads on accept.
  - Otherwise holds until transfer.
  - Transfer without a new accept clears out_valid.
  - Back-to-back throughput is 1 per cycle when out_ready=1.
- Flush (synchronous):
  - Next edge: out_valid=0; any in-progress shift aborts to IDLE; busy=0.
  - in_ready=0 during flush, so a simultaneous in_valid is dropped.
  - Flush has priority over accept and over transfer.
- out_rd_addr/out_rd_wen travel with the result; their values are don't-care when out_valid=0, but they are cleared by reset.

Optional Feature:
- Macro: CORE_ALU_SERIAL_SHIFT_EN.
- Defined: SLL/SRL/SRA use an iterative 1-bit-per-cycle shifter instead of a barrel shifter.
  - FSM: IDLE -> SHIFT on accepting a shift op with shamt!=0.
  - Capture op1, the remaining count, and the rd fields; busy=1.
  - Each SHIFT cycle shifts by 1 and decrements the count.
  - When count reaches 0: load the output register, out_valid=1, busy=0, return to IDLE.
  - Latency is shamt+1 cycles. A shift op with shamt=0 completes in 1 cycle without entering SHIFT.
  - SHIFT only completes when the output register is free (!out_valid || out_ready); otherwise it waits with count=0.
  - Flush or reset in SHIFT returns the FSM to IDLE with no output.
- Undefined: all shifts are single-cycle; busy tied to 0; no FSM.

Test Plan:
- ADD, op1=32'hFFFF_FFFF, op2=1, out_ready=1 -> next cycle out_valid=1, out_result=0; SUB 0-1 -> 32'hFFFF_FFFF.
- SLT op1=32'h8000_0000, op2=1 -> 1; SLTU same operands -> 0; NOT_AND op1=32'hF0F0, op2=32'h00FF -> 32'hF000.
- SRA op1=32'h8000_0010, op2=4 -> 32'hF800_0001. Serial build: busy high 4 cycles, out_valid on cycle 5. Barrel build: cycle 1.
- Backpressure: out_ready=0 while 3 back-to-back ADDs are presented -> first result held, in_ready=0, no entry lost; out_ready=1 -> results emerge in order, one per cycle.
- Flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, the input is not accepted. Serial build: flush during SLL by 20 -> busy=0 next cycle, no result.
- Assert rst_n=0 mid-shift and while out_valid=1 -> all outputs 0 immediately; after release, an ADD 2+3 returns 5.

Source files
------------

// File: rtl/core_ex_alu_if.sv
// Handshake bundle between the ID/EX register, the EX-stage ALU and the EX/MEM boundary.
// master = upstream/downstream environment, slave = core_ex_alu.
interface core_ex_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_alu_op;
    logic [XLEN-1:0] in_op1;
    logic [XLEN-1:0] in_op2;
    logic [4:0]      in_rd_addr;
    logic            in_rd_wen;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd_addr;
    logic            out_rd_wen;
    logic            busy;

    modport master (
        output in_valid, in_alu_op, in_op1, in_op2, in_rd_addr, in_rd_wen, out_ready,
        input  in_ready, out_valid, out_result, out_rd_addr, out_rd_wen, busy
    );

    modport slave (
        input  in_valid, in_alu_op, in_op1, in_op2, in_rd_addr, in_rd_wen, out_ready,
        output in_ready, out_valid, out_result, out_rd_addr, out_rd_wen, busy
    );
endinterface

// File: rtl/core_ex_alu.sv
// Execute-stage ALU with a registered valid/ready result slot and flush.
// Define CORE_ALU_SERIAL_SHIFT_EN to replace the barrel shifter with a 1-bit-per-cycle shifter.
`ifndef ALU_OP_ADD
`define ALU_OP_ADD     4'd0
`define ALU_OP_SUB     4'd1
`define ALU_OP_SLL     4'd2
`define ALU_OP_SLT     4'd3
`define ALU_OP_SLTU    4'd4
`define ALU_OP_XOR     4'd5
`define ALU_OP_SRL     4'd6
`define ALU_OP_SRA     4'd7
`define ALU_OP_OR      4'd8
`define ALU_OP_AND     4'd9
`define ALU_OP_NOT_AND 4'd10
`endif

module core_ex_alu #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    core_ex_alu_if.slave  bus
);
    localparam int SW = $clog2(XLEN);

    logic            out_valid_r;
    logic [XLEN-1:0] out_result_r;
    logic [4:0]      out_rd_addr_r;
    logic            out_rd_wen_r;

    logic            busy_s;
    logic            out_free_s;
    logic            in_ready_s;
    logic            accept_s;
    logic [XLEN-1:0] result_s;

    function automatic logic [XLEN-1:0] alu_compute(
        input logic [3:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] res;
`ifndef CORE_ALU_SERIAL_SHIFT_EN
        logic [SW-1:0]   shamt;
        shamt = b[SW-1:0];
`endif
        case (op)
            `ALU_OP_ADD:     res = a + b;
            `ALU_OP_SUB:     res = a - b;
            `ALU_OP_SLT:     res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            `ALU_OP_SLTU:    res = {{(XLEN-1){1'b0}}, (a < b)};
            `ALU_OP_XOR:     res = a ^ b;
            `ALU_OP_OR:      res = a | b;
            `ALU_OP_AND:     res = a & b;
            `ALU_OP_NOT_AND: res = a & ~b;
`ifdef CORE_ALU_SERIAL_SHIFT_EN
            // Only a zero shift amount reaches this path; longer shifts go through the FSM
            `ALU_OP_SLL, `ALU_OP_SRL, `ALU_OP_SRA: res = a;
`else
            `ALU_OP_SLL:     res = a << shamt;
            `ALU_OP_SRL:     res = a >> shamt;
            `ALU_OP_SRA:     res = $unsigned($signed(a) >>> shamt);
`endif
            default:         res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    assign out_free_s = !out_valid_r || bus.out_ready;
    assign in_ready_s = !flush && !busy_s && out_free_s;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign result_s   = alu_compute(bus.in_alu_op, bus.in_op1, bus.in_op2);

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = out_result_r;
    assign bus.out_rd_addr = out_rd_addr_r;
    assign bus.out_rd_wen  = out_rd_wen_r;
    assign bus.busy        = busy_s;

`ifdef CORE_ALU_SERIAL_SHIFT_EN
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic [SW-1:0] CNT_ONE = SW'(1'b1);

    state_e          state_r;
    logic            busy_r;
    logic [XLEN-1:0] sh_data_r;
    logic [SW-1:0]   sh_cnt_r;
    logic [3:0]      sh_op_r;
    logic [4:0]      sh_rd_addr_r;
    logic            sh_rd_wen_r;

    logic [SW-1:0]   shamt_s;
    logic            is_shift_s;
    logic            start_shift_s;
    logic [XLEN-1:0] sh_step_s;

    assign busy_s        = busy_r;
    assign shamt_s       = bus.in_op2[SW-1:0];
    assign is_shift_s    = (bus.in_alu_op == `ALU_OP_SLL) || (bus.in_alu_op == `ALU_OP_SRL) ||
                           (bus.in_alu_op == `ALU_OP_SRA);
    assign start_shift_s = accept_s && is_shift_s && (shamt_s != {SW{1'b0}});

    // One-bit step of the captured operand in the direction of the captured op
    always_comb begin
        sh_step_s = sh_data_r;
        case (sh_op_r)
            `ALU_OP_SLL: sh_step_s = {sh_data_r[XLEN-2:0], 1'b0};
            `ALU_OP_SRL: sh_step_s = {1'b0, sh_data_r[XLEN-1:1]};
            `ALU_OP_SRA: sh_step_s = {sh_data_r[XLEN-1], sh_data_r[XLEN-1:1]};
            default:     sh_step_s = sh_data_r;
        endcase
    end

    // Shift FSM and result slot; the last shift step writes the slot directly when it is free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            sh_data_r     <= {XLEN{1'b0}};
            sh_cnt_r      <= {SW{1'b0}};
            sh_op_r       <= 4'd0;
            sh_rd_addr_r  <= 5'd0;
            sh_rd_wen_r   <= 1'b0;
            out_valid_r   <= 1'b0;
            out_result_r  <= {XLEN{1'b0}};
            out_rd_addr_r <= 5'd0;
            out_rd_wen_r  <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_shift_s) begin
                        state_r      <= ST_SHIFT;
                        busy_r       <= 1'b1;
                        sh_data_r    <= bus.in_op1;
                        sh_cnt_r     <= shamt_s;
                        sh_op_r      <= bus.in_alu_op;
                        sh_rd_addr_r <= bus.in_rd_addr;
                        sh_rd_wen_r  <= bus.in_rd_wen;
                    end else if (accept_s) begin
                        out_valid_r   <= 1'b1;
                        out_result_r  <= result_s;
                        out_rd_addr_r <= bus.in_rd_addr;
                        out_rd_wen_r  <= bus.in_rd_wen;
                    end
                end
                ST_SHIFT: begin
                    if (sh_cnt_r == {SW{1'b0}}) begin
                        if (out_free_s) begin
                            state_r       <= ST_IDLE;
                            busy_r        <= 1'b0;
                            out_valid_r   <= 1'b1;
                            out_result_r  <= sh_data_r;
                            out_rd_addr_r <= sh_rd_addr_r;
                            out_rd_wen_r  <= sh_rd_wen_r;
                        end
                    end else if ((sh_cnt_r == CNT_ONE) && out_free_s) begin
                        state_r       <= ST_IDLE;
                        busy_r        <= 1'b0;
                        sh_cnt_r      <= {SW{1'b0}};
                        out_valid_r   <= 1'b1;
                        out_result_r  <= sh_step_s;
                        out_rd_addr_r <= sh_rd_addr_r;
                        out_rd_wen_r  <= sh_rd_wen_r;
                    end else begin
                        sh_data_r <= sh_step_s;
                        sh_cnt_r  <= sh_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign busy_s = 1'b0;

    // Result slot: flush beats accept, accept beats plain transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_result_r  <= {XLEN{1'b0}};
            out_rd_addr_r <= 5'd0;
            out_rd_wen_r  <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r   <= 1'b1;
            out_result_r  <= result_s;
            out_rd_addr_r <= bus.in_rd_addr;
            out_rd_wen_r  <= bus.in_rd_wen;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end
`endif
endmodule
